// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter that lends one shared tick timer to several requesters.
// The owner holds grant until its delay in ticks expires (done pulse) or it drops req.
module tick_timer_arbiter #(
    parameter int INPUT_CLOCK  = 27000000,
    parameter int OUTPUT_CLOCK = 1000,
    parameter int REQUESTERS   = 4,
    parameter int DELAY_W      = 16,
    localparam int ID_W        = $clog2(REQUESTERS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [REQUESTERS-1:0]         req,
    input  logic [REQUESTERS*DELAY_W-1:0] delay,
    output logic [REQUESTERS-1:0]         grant,
    output logic [REQUESTERS-1:0]         done,
    output logic                          busy,
    output logic [ID_W-1:0]               active_id
);

    localparam int TICKS = INPUT_CLOCK / OUTPUT_CLOCK;
    localparam int CNT_W = $clog2(TICKS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DELAY_W-1:0]      rem_q, rem_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [REQUESTERS-1:0]   grant_q, grant_d;
    logic [REQUESTERS-1:0]   done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    tick;
    logic                    found;
    logic [ID_W-1:0]         sel;
    logic [ID_W-1:0]         idx;
    logic [ID_W-1:0]         next_ptr;
    logic [DELAY_W-1:0]      dly [REQUESTERS];

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_dly
        assign dly[g] = delay[g*DELAY_W +: DELAY_W];
    end

    assign tick     = (cnt_q == CNT_W'(TICKS - 1));
    assign next_ptr = (id_q == ID_W'(REQUESTERS - 1)) ? '0 : id_q + 1'b1;

    // First set request at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % REQUESTERS);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    rem_d   = dly[sel];
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // A dropped request wins over a simultaneously expiring delay.
                if (!req[id_q]) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                    ptr_d   = next_ptr;
                end else if (tick) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == DELAY_W'(1)) begin
                        state_d = DONE;
                        ptr_d   = next_ptr;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = next_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d    = id_q;
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        unique case (state_d)
            IDLE: ;
            RUN: begin
                if (state_q == IDLE) id_d = sel;
                grant_d = REQUESTERS'(1) << id_d;
                busy_d  = 1'b1;
            end
            DONE: begin
                grant_d = REQUESTERS'(1) << id_q;
                done_d  = REQUESTERS'(1) << id_q;
                busy_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign active_id = id_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter with TICKS=10, 4 requesters, 8-bit delays.
module tb_tick_timer_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] delay;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  active_id;

    int tests;
    int fails;

    tick_timer_arbiter #(
        .INPUT_CLOCK (100),
        .OUTPUT_CLOCK(10),
        .REQUESTERS  (4),
        .DELAY_W     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .delay    (delay),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .active_id(active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_delay(input int i, input logic [7:0] v);
        delay[i*8 +: 8] = v;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req   = '0;
        delay = '0;
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_id", 32'(active_id), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // single request, delay 3
        req = 4'b0001;
        set_delay(0, 8'd3);
        step(1);
        check("single_c0_grant", 32'(grant), 32'h1);
        check("single_c0_busy", 32'(busy), 32'h1);
        check("single_c0_id", 32'(active_id), 32'h0);
        check("single_c0_done", 32'(done), 32'h0);
        step(29);
        check("single_c29_done", 32'(done), 32'h0);
        step(1);
        check("single_c30_done", 32'(done), 32'h1);
        check("single_c30_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        step(1);
        check("single_c31_grant", 32'(grant), 32'h0);
        check("single_c31_busy", 32'(busy), 32'h0);
        check("single_c31_done", 32'(done), 32'h0);

        // zero delay on requester 2
        req = 4'b0100;
        set_delay(2, 8'd0);
        step(1);
        check("zero_c0_grant", 32'(grant), 32'h4);
        check("zero_c0_id", 32'(active_id), 32'h2);
        step(1);
        check("zero_c1_done", 32'(done), 32'h4);
        req = 4'b0000;
        step(1);
        check("zero_c2_grant", 32'(grant), 32'h0);
        check("zero_c2_done", 32'(done), 32'h0);

        // delay input changed mid-grant is ignored
        req = 4'b0001;
        set_delay(0, 8'd3);
        step(1);
        check("dchg_c0_grant", 32'(grant), 32'h1);
        step(5);
        set_delay(0, 8'd7);
        step(24);
        check("dchg_c29_done", 32'(done), 32'h0);
        step(1);
        check("dchg_c30_done", 32'(done), 32'h1);
        req = 4'b0000;
        step(1);
        check("dchg_c31_grant", 32'(grant), 32'h0);

        // abort by dropping req
        req = 4'b0010;
        set_delay(1, 8'd5);
        step(1);
        check("abort_c0_grant", 32'(grant), 32'h2);
        check("abort_c0_id", 32'(active_id), 32'h1);
        step(17);
        req = 4'b0000;
        step(1);
        check("abort_c18_grant", 32'(grant), 32'h0);
        check("abort_c18_busy", 32'(busy), 32'h0);
        check("abort_c18_done", 32'(done), 32'h0);
        check("abort_hold_id", 32'(active_id), 32'h1);
        step(1);
        check("abort_c19_done", 32'(done), 32'h0);
        req = 4'b0110;
        step(1);
        check("abort_next_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        step(1);
        check("abort_next_idle", 32'(grant), 32'h0);

        // reset in the middle of a run
        req = 4'b0001;
        set_delay(0, 8'd4);
        step(1);
        check("rrun_c0_grant", 32'(grant), 32'h1);
        step(25);
        rst_n = 1'b0;
        #1;
        check("rrun_async_grant", 32'(grant), 32'h0);
        check("rrun_async_busy", 32'(busy), 32'h0);
        check("rrun_async_done", 32'(done), 32'h0);
        step(2);
        check("rrun_hold_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        step(1);
        check("rrun_regrant", 32'(grant), 32'h1);
        step(39);
        check("rrun_c39_done", 32'(done), 32'h0);
        step(1);
        check("rrun_c40_done", 32'(done), 32'h1);
        req = 4'b0000;
        step(1);
        check("rrun_c41_grant", 32'(grant), 32'h0);

        // contention with all requesters after a fresh reset
        rst_n = 1'b0;
        #1;
        step(1);
        for (int i = 0; i < 4; i++) set_delay(i, 8'd1);
        req   = 4'b1111;
        rst_n = 1'b1;
        step(1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("cont%0d_grant", k), 32'(grant), 32'(1 << (k % 4)));
            check($sformatf("cont%0d_id", k), 32'(active_id), 32'(k % 4));
            step(9);
            check($sformatf("cont%0d_c9_done", k), 32'(done), 32'h0);
            step(1);
            check($sformatf("cont%0d_done", k), 32'(done), 32'(1 << (k % 4)));
            step(1);
            check($sformatf("cont%0d_gap", k), 32'(grant), 32'h0);
            check($sformatf("cont%0d_gap_busy", k), 32'(busy), 32'h0);
            step(1);
        end
        req = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
